// File: rtl/autorange_ctrl_if.sv
// Bundle between the autorange sequencer, the conversion FSM and the readout/host logic.
// Handshake rules: conv_start_o, conv_done_i and meas_valid_o are single-cycle
// pulses with no back-pressure. conv_count_i/conv_sat_i are meaningful only
// while conv_done_i=1. meas_count_o/meas_range_o/meas_ovr_o change only on the
// edge that raises meas_valid_o, and hold until the next accepted result.
interface autorange_ctrl_if #(
    parameter int RANGE_SEL_WIDTH = 2,
    parameter int COUNT_WIDTH     = 32
);
    logic                       start_i;
    logic                       abort_i;
    logic                       conv_start_o;
    logic                       conv_done_i;
    logic [COUNT_WIDTH-1:0]     conv_count_i;
    logic                       conv_sat_i;
    logic                       conv_error_i;
    logic [RANGE_SEL_WIDTH-1:0] range_sel_o;
    logic                       busy_o;
    logic                       meas_valid_o;
    logic [COUNT_WIDTH-1:0]     meas_count_o;
    logic [RANGE_SEL_WIDTH-1:0] meas_range_o;
    logic                       meas_ovr_o;
    logic                       error_o;
    logic [1:0]                 err_code_o;
    logic [2:0]                 state_o;

    modport master (
        output start_i, abort_i, conv_done_i, conv_count_i, conv_sat_i, conv_error_i,
        input  conv_start_o, range_sel_o, busy_o, meas_valid_o, meas_count_o,
               meas_range_o, meas_ovr_o, error_o, err_code_o, state_o
    );

    modport slave (
        input  start_i, abort_i, conv_done_i, conv_count_i, conv_sat_i, conv_error_i,
        output conv_start_o, range_sel_o, busy_o, meas_valid_o, meas_count_o,
               meas_range_o, meas_ovr_o, error_o, err_code_o, state_o
    );
endinterface

// File: rtl/autorange_ctrl.sv
// Autorange measurement sequencer: runs conversions, steps the front-end range
// until the count lands in the usable window, and reports one result per measurement.
module autorange_ctrl #(
    parameter int RANGE_SEL_WIDTH = 2,
    parameter int NUM_RANGES      = 4,
    parameter int COUNT_WIDTH     = 32,
    parameter int HI_THRESH       = 900,
    parameter int LO_THRESH       = 80,
    parameter int SETTLE_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int MAX_STEPS       = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    autorange_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(MAX_STEPS + 1);
    localparam logic [RANGE_SEL_WIDTH-1:0] TOP_RANGE = RANGE_SEL_WIDTH'(NUM_RANGES - 1);
    localparam logic [COUNT_WIDTH-1:0]     HI        = COUNT_WIDTH'(HI_THRESH);
    localparam logic [COUNT_WIDTH-1:0]     LO        = COUNT_WIDTH'(LO_THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_EVAL   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                     state_q, state_d;
    logic [SW-1:0]              settle_q, settle_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [PW-1:0]              step_q, step_d;
    logic [RANGE_SEL_WIDTH-1:0] range_q, range_d;
    logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                       sat_q, sat_d;
    logic [COUNT_WIDTH-1:0]     mcount_q, mcount_d;
    logic [RANGE_SEL_WIDTH-1:0] mrange_q, mrange_d;
    logic                       movr_q, movr_d;
    logic                       error_q, error_d;
    logic [1:0]                 code_q, code_d;

    logic                       over;
    logic                       under;
    logic                       step_req;
    logic [RANGE_SEL_WIDTH-1:0] step_range;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        step_d     = step_q;
        range_d    = range_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        mcount_d   = mcount_q;
        mrange_d   = mrange_q;
        movr_d     = movr_q;
        error_d    = error_q;
        code_d     = code_q;

        // Range decision from the latched conversion; step-up outranks step-down.
        over       = sat_q | (cnt_q > HI);
        under      = ~sat_q & (cnt_q < LO);
        step_req   = 1'b0;
        step_range = range_q;
        if (over && (range_q != TOP_RANGE)) begin
            step_req   = 1'b1;
            step_range = range_q + 1'b1;
        end else if (under && (range_q != '0)) begin
            step_req   = 1'b1;
            step_range = range_q - 1'b1;
        end

        if (bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_d  = S_SETTLE;
                        settle_d = '0;
                        step_d   = '0;
                        error_d  = 1'b0;
                        code_d   = 2'b00;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_d = S_START;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_START: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.conv_error_i) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b11;
                    end else if (bus.conv_done_i) begin
                        cnt_d   = bus.conv_count_i;
                        sat_d   = bus.conv_sat_i;
                        state_d = S_EVAL;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (step_req && (step_q == PW'(MAX_STEPS))) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b10;
                    end else if (step_req) begin
                        range_d  = step_range;
                        step_d   = step_q + 1'b1;
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end else begin
                        // over can only survive to here on the top range.
                        mcount_d = cnt_q;
                        mrange_d = range_q;
                        movr_d   = over;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.start_i) begin
                        state_d  = S_SETTLE;
                        settle_d = '0;
                        step_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (!bus.start_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            step_q   <= '0;
            range_q  <= TOP_RANGE;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            mcount_q <= '0;
            mrange_q <= '0;
            movr_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            step_q   <= step_d;
            range_q  <= range_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            mcount_q <= mcount_d;
            mrange_q <= mrange_d;
            movr_q   <= movr_d;
            error_q  <= error_d;
            code_q   <= code_d;
        end
    end

    assign bus.conv_start_o = (state_q == S_START) && !bus.abort_i;
    assign bus.busy_o       = (state_q == S_SETTLE) || (state_q == S_START) ||
                              (state_q == S_WAIT)   || (state_q == S_EVAL)  ||
                              (state_q == S_DONE);
    assign bus.meas_valid_o = (state_q == S_DONE);
    assign bus.meas_count_o = mcount_q;
    assign bus.meas_range_o = mrange_q;
    assign bus.meas_ovr_o   = movr_q;
    assign bus.range_sel_o  = range_q;
    assign bus.error_o      = error_q;
    assign bus.err_code_o   = code_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_autorange_ctrl.sv
// Directed bench for autorange_ctrl: a per-range response table plays the analog
// input, a vector table drives whole measurements, hand sequences cover timing corners.
module tb_autorange_ctrl;

  localparam int RW = 2;
  localparam int CW = 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_SETTLE = 3'd1, ST_WAIT = 3'd3, ST_ERROR = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  autorange_ctrl_if #(.RANGE_SEL_WIDTH(RW), .COUNT_WIDTH(CW)) bus ();

  autorange_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0][31:0] cnt;
    logic [3:0]       sat;
    logic             inj_err;
    logic [31:0]      exp_count;
    logic [1:0]       exp_range;
    logic             exp_ovr;
    logic [1:0]       exp_code;
    logic [3:0]       exp_starts;
    logic [15:0]      exp_trace;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] resp_cnt [4];
  logic        resp_sat [4];
  logic        resp_err;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_count = '0;
  logic [1:0]  last_range = '0;
  logic        last_ovr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int c3, input int c2, input int c1, input int c0,
                              input logic [3:0] s, input logic ie, input int ecount,
                              input int erange, input logic eovr, input int ecode,
                              input int est, input int etr);
    vec_t v;
    v = '0;
    v.cnt[3] = 32'(c3);
    v.cnt[2] = 32'(c2);
    v.cnt[1] = 32'(c1);
    v.cnt[0] = 32'(c0);
    v.sat = s;
    v.inj_err = ie;
    v.exp_count = 32'(ecount);
    v.exp_range = 2'(erange);
    v.exp_ovr = eovr;
    v.exp_code = 2'(ecode);
    v.exp_starts = 4'(est);
    v.exp_trace = 16'(etr);
    return v;
  endfunction

  // Plays the conversion FSM: done arrives 3 cycles after each start pulse with
  // the table entry for the range currently selected. Stops at meas_valid_o or error_o.
  task automatic respond(input int limit, input logic drop_start, output int first_start,
                         output int end_at, output int n_starts, output logic [15:0] trace,
                         output logic ended_err);
    int delay;
    delay = -1;
    first_start = -1;
    end_at = -1;
    n_starts = 0;
    trace = '0;
    ended_err = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (drop_start && cyc == 1) bus.start_i = 1'b0;
      bus.conv_done_i = 1'b0;
      bus.conv_error_i = 1'b0;
      if (bus.meas_valid_o) begin
        end_at = cyc;
        break;
      end
      if (bus.error_o) begin
        end_at = cyc;
        ended_err = 1'b1;
        break;
      end
      if (bus.conv_start_o) begin
        n_starts++;
        if (first_start < 0) first_start = cyc;
        trace = {trace[13:0], bus.range_sel_o};
        delay = 3;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          bus.conv_done_i = 1'b1;
          bus.conv_count_i = resp_cnt[bus.range_sel_o];
          bus.conv_sat_i = resp_sat[bus.range_sel_o];
          bus.conv_error_i = resp_err;
        end
      end
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    n = -1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (bus.conv_start_o) begin
        n = cyc;
        break;
      end
    end
  endtask

  task automatic run_meas(input vec_t v, input int idx);
    int fs, ea, ns, extra_valid;
    logic [15:0] tr;
    logic ee;
    string nm;
    nm = $sformatf("v%0d", idx);
    for (int r = 0; r < 4; r++) begin
      resp_cnt[r] = v.cnt[r];
      resp_sat[r] = v.sat[r];
    end
    resp_err = v.inj_err;
    bus.start_i = 1'b1;
    respond(600, 1'b1, fs, ea, ns, tr, ee);
    check({nm, "_ended"}, 64'(ea > 0), 1);
    check({nm, "_first_start"}, 64'(fs), 9);
    check({nm, "_starts"}, 64'(ns), 64'(v.exp_starts));
    check({nm, "_trace"}, tr, v.exp_trace);
    if (v.exp_code == 2'b00) begin
      check({nm, "_is_accept"}, ee, 0);
      check({nm, "_count"}, bus.meas_count_o, v.exp_count);
      check({nm, "_range"}, bus.meas_range_o, v.exp_range);
      check({nm, "_ovr"}, bus.meas_ovr_o, v.exp_ovr);
      check({nm, "_error"}, bus.error_o, 0);
      last_count = v.exp_count;
      last_range = v.exp_range;
      last_ovr = v.exp_ovr;
    end else begin
      check({nm, "_is_error"}, ee, 1);
      check({nm, "_code"}, bus.err_code_o, v.exp_code);
      check({nm, "_range_sel"}, bus.range_sel_o, v.exp_range);
      check({nm, "_count_held"}, bus.meas_count_o, last_count);
      check({nm, "_mrange_held"}, bus.meas_range_o, last_range);
    end
    extra_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.meas_valid_o) extra_valid++;
      if (k == 0) check({nm, "_busy_after"}, bus.busy_o, 0);
    end
    check({nm, "_extra_valid"}, 64'(extra_valid), 0);
    if (v.exp_code != 2'b00) check({nm, "_error_sticky"}, bus.error_o, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, ea, ns, n;
    logic [15:0] tr;
    logic ee;

    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.conv_done_i = 1'b0;
    bus.conv_count_i = '0;
    bus.conv_sat_i = 1'b0;
    bus.conv_error_i = 1'b0;
    resp_err = 1'b0;
    for (int r = 0; r < 4; r++) begin
      resp_cnt[r] = 32'd500;
      resp_sat[r] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_range_sel", bus.range_sel_o, 3);
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.meas_valid_o, 0);
    check("rst_conv_start", bus.conv_start_o, 0);
    check("rst_error", bus.error_o, 0);
    check("rst_code", bus.err_code_o, 0);
    check("rst_count", bus.meas_count_o, 0);
    check("rst_ovr", bus.meas_ovr_o, 0);
    check("rst_state", bus.state_o, ST_IDLE);

    //            c3    c2    c1   c0   sat      ie    cnt   rng ovr code st trace
    vecs[0]  = mk(500,  500,  500, 500, 4'b0000, 1'b0, 500,  3, 1'b0, 0, 1, 16'h0003);
    vecs[1]  = mk(40,   60,   300, 0,   4'b0000, 1'b0, 300,  1, 1'b0, 0, 3, 16'h0039);
    vecs[2]  = mk(0,    0,    5,   5,   4'b0000, 1'b0, 5,    0, 1'b0, 0, 2, 16'h0004);
    vecs[3]  = mk(0,    450,  950, 100, 4'b0001, 1'b0, 450,  2, 1'b0, 0, 3, 16'h0006);
    vecs[4]  = mk(1000, 1000, 0,   0,   4'b1100, 1'b0, 1000, 3, 1'b1, 0, 2, 16'h000B);
    vecs[5]  = mk(901,  0,    0,   0,   4'b0000, 1'b0, 901,  3, 1'b1, 0, 1, 16'h0003);
    vecs[6]  = mk(900,  0,    0,   0,   4'b0000, 1'b0, 900,  3, 1'b0, 0, 1, 16'h0003);
    vecs[7]  = mk(80,   0,    0,   0,   4'b0000, 1'b0, 80,   3, 1'b0, 0, 1, 16'h0003);
    vecs[8]  = mk(79,   900,  0,   0,   4'b0000, 1'b0, 900,  2, 1'b0, 0, 2, 16'h000E);
    vecs[9]  = mk(40,   950,  0,   0,   4'b0000, 1'b0, 0,    2, 1'b0, 2, 5, 16'h02EE);
    vecs[10] = mk(0,    500,  0,   0,   4'b0000, 1'b0, 500,  2, 1'b0, 0, 1, 16'h0002);
    vecs[11] = mk(0,    500,  0,   0,   4'b0000, 1'b1, 0,    2, 1'b0, 3, 1, 16'h0002);

    for (int i = 0; i < 12; i++) run_meas(vecs[i], i);

    // Back-to-back measurements with start_i held; range 2 is remembered.
    for (int r = 0; r < 4; r++) begin
      resp_cnt[r] = 32'd500;
      resp_sat[r] = 1'b0;
    end
    resp_err = 1'b0;
    bus.start_i = 1'b1;
    respond(300, 1'b0, fs, ea, ns, tr, ee);
    check("b2b_first_end", 64'(ea > 0 && !ee), 1);
    check("b2b_first_start", 64'(fs), 9);
    check("b2b_first_range", bus.meas_range_o, 2);
    check("b2b_first_error", bus.error_o, 0);
    respond(300, 1'b0, fs, ea, ns, tr, ee);
    bus.start_i = 1'b0;
    check("b2b_second_end", 64'(ea > 0 && !ee), 1);
    check("b2b_restart_gap", 64'(fs), 9);
    check("b2b_second_range", tr, 2);
    check("b2b_second_count", bus.meas_count_o, 500);
    last_count = 32'd500;
    last_range = 2'd2;
    repeat (2) @(negedge clk);
    check("b2b_idle_state", bus.state_o, ST_IDLE);

    // conv_done_i outside WAIT is ignored; abort in WAIT returns to IDLE with no result.
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.conv_done_i = 1'b1;
    bus.conv_count_i = 32'd7;
    @(negedge clk);
    bus.conv_done_i = 1'b0;
    check("stray_done_state", bus.state_o, ST_SETTLE);
    wait_start(50, n);
    check("stray_done_start_at", 64'(n), 6);
    repeat (2) @(negedge clk);
    check("abort_pre_state", bus.state_o, ST_WAIT);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_state", bus.state_o, ST_IDLE);
    check("abort_busy", bus.busy_o, 0);
    check("abort_valid", bus.meas_valid_o, 0);
    check("abort_count_held", bus.meas_count_o, last_count);
    check("abort_range_kept", bus.range_sel_o, 2);

    // Timeout with start_i held: ERROR persists until abort.
    bus.start_i = 1'b1;
    wait_start(50, n);
    check("tmo_start_at", 64'(n), 9);
    n = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (bus.error_o) begin
        n = cyc;
        break;
      end
    end
    check("tmo_error_at", 64'(n), 101);
    check("tmo_code", bus.err_code_o, 1);
    check("tmo_busy", bus.busy_o, 0);
    check("tmo_state", bus.state_o, ST_ERROR);
    repeat (4) @(negedge clk);
    check("tmo_error_held_state", bus.state_o, ST_ERROR);
    check("tmo_no_conv_start", bus.conv_start_o, 0);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    check("tmo_abort_state", bus.state_o, ST_IDLE);
    @(negedge clk);
    check("tmo_error_sticky", bus.error_o, 1);
    check("tmo_code_sticky", bus.err_code_o, 1);

    // Asynchronous reset in the middle of WAIT.
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_start(50, n);
    check("rstmid_start_at", 64'(n), 8);
    repeat (2) @(negedge clk);
    check("rstmid_pre_state", bus.state_o, ST_WAIT);
    rst_n = 1'b0;
    #1;
    check("rstmid_range_sel", bus.range_sel_o, 3);
    check("rstmid_busy", bus.busy_o, 0);
    check("rstmid_state", bus.state_o, ST_IDLE);
    check("rstmid_count", bus.meas_count_o, 0);
    check("rstmid_mrange", bus.meas_range_o, 0);
    check("rstmid_valid", bus.meas_valid_o, 0);
    check("rstmid_conv_start", bus.conv_start_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autorange_ctrl.md
Name: autorange_ctrl

Overview:
Measurement sequencer that sits above the dual-slope conversion FSM and drives its range selection. Each measurement runs one or more conversions. After each conversion it checks the count and the saturation flag, then steps the range up or down until the result sits inside the usable window. It returns one accepted result per measurement, with range and overrange flags, to the readout/host logic.

Parameters:
RANGE_SEL_WIDTH, 2, width of range index.
NUM_RANGES, 4, number of valid ranges. Index 0 is most sensitive; NUM_RANGES-1 is least sensitive.
COUNT_WIDTH, 32, width of conversion count.
HI_THRESH, 900, count above which the controller steps to a less sensitive range.
LO_THRESH, 80, count below which the controller steps to a more sensitive range.
SETTLE_CYCLES, 8, front-end settle delay after each start or range change.
TIMEOUT_CYCLES, 65535, maximum cycles to wait for conv_done_i.
MAX_STEPS, 4, maximum range changes per measurement.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  level request; while held high, measurements repeat back-to-back
abort_i  in  1  synchronous abort; returns to IDLE from any state
conv_start_o  out  1  one-cycle start pulse to the conversion FSM
conv_done_i  in  1  one-cycle pulse, conversion complete
conv_count_i  in  COUNT_WIDTH  conversion count, valid with conv_done_i
conv_sat_i  in  1  integrator saturated during the conversion, valid with conv_done_i
conv_error_i  in  1  conversion FSM fault (reference not ok, etc.)
range_sel_o  out  RANGE_SEL_WIDTH  range applied to the analog front end
busy_o  out  1  measurement in progress
meas_valid_o  out  1  one-cycle pulse, result accepted
meas_count_o  out  COUNT_WIDTH  accepted count, held until the next accept
meas_range_o  out  RANGE_SEL_WIDTH  range of the accepted count
meas_ovr_o  out  1  overrange: saturated or above HI_THRESH on top range
error_o  out  1  sticky fault flag
err_code_o  out  2  01 timeout, 10 hunting limit, 11 conversion fault

Behaviour:
- Reset values:
  - state=IDLE
  - range_sel_o=NUM_RANGES-1
  - all other outputs 0
  - internal counters 0
- States: IDLE, SETTLE, START, WAIT, EVAL, DONE, ERROR.
- IDLE:
  - busy_o=0.
  - When start_i=1, go to SETTLE. Clear the step counter and the settle counter. Clear error_o/err_code_o.
- SETTLE:
  - Count SETTLE_CYCLES clocks, then go to START.
  - Total time from leaving IDLE to conv_start_o = SETTLE_CYCLES+1 cycles.
- START:
  - conv_start_o=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - conv_error_i=1 → ERROR, code 11.
  - conv_done_i → latch count and sat, go to EVAL.
  - Timeout counter reaches TIMEOUT_CYCLES with no done → ERROR, code 01.
  - conv_error_i has priority over a simultaneous conv_done_i.
- EVAL (one cycle), evaluated in this order:
  1. Step up: if (sat or count>HI_THRESH) and range<NUM_RANGES-1, the next action is range+1.
  2. Step down: else if count<LO_THRESH and sat=0 and range>0, the next action is range-1.
  3. Accept: else go to DONE.
  - Sat on the top range, or count>HI_THRESH on the top range → accept with meas_ovr_o=1.
  - Count<LO_THRESH on range 0 → accept with ovr=0.
  - Range change with step counter == MAX_STEPS → ERROR, code 10. Range is left unchanged.
  - Range change otherwise: update range_sel_o, increment the step counter, go to SETTLE.
  - Comparisons are unsigned and strict.
- DONE:
  - meas_valid_o=1 for one cycle.
  - meas_count_o, meas_range_o and meas_ovr_o update on the same edge as the pulse, and hold afterwards.
  - Next state: start_i=1 → SETTLE (step counter cleared, range retained); otherwise IDLE.
- ERROR:
  - error_o=1, busy_o=0, conv_start_o=0.
  - Stays in ERROR until abort_i=1 or start_i=0, then goes to IDLE.
  - error_o/err_code_o persist until the next measurement is accepted out of IDLE.
- busy_o=1 in SETTLE, START, WAIT, EVAL and DONE.
- range_sel_o:
  - Changes only on the EVAL→SETTLE edge.
  - Retained across measurements; this is the autorange memory.
  - Reset to NUM_RANGES-1 so the first conversion runs on the safest range.
- abort_i:
  - From any state, next state is IDLE. conv_start_o=0 that cycle.
  - The meas_* outputs are not updated.
  - range_sel_o is retained.
  - An abort in DONE still leaves the already-issued pulse intact.
- Reset asserted mid-operation: all state and outputs return to reset values asynchronously. No meas_valid_o pulse.
- conv_done_i outside WAIT is ignored.

Test Plan:
- Reset, then start_i=1 pulse held 1 cycle, conv_done_i with count=500 on range 3 → conv_start_o 9 cycles after start; one meas_valid_o with count=500, range=3, ovr=0; busy_o falls the following cycle.
- Range 3 returns count=40, range 2 returns 60, range 1 returns 300 → range_sel_o steps 3→2→1; accept count=300, range=1; exactly 3 conv_start_o pulses.
- Range 0 returns sat=1, range 1 returns count=950, range 2 returns 450 → steps up twice; accept 450 on range 2, ovr=0.
- Range 3 returns sat=1 → accepted, meas_ovr_o=1, range=3. Separately, range 0 returns count=5 → accepted, ovr=0.
- No conv_done_i, TIMEOUT_CYCLES=100 → ERROR at cycle 100 of WAIT, err_code_o=01. Set MAX_STEPS=1 and alternate 40/950 → ERROR with code 10. conv_error_i and conv_done_i in the same cycle → code 11.
- start_i held high → back-to-back measurements, range retained between them. abort_i during WAIT → IDLE next cycle with no meas_valid_o. rst_ni low mid-WAIT → all outputs at reset values immediately.
